// File: rtl/uart_cmd_pkg.sv
// Shared types for the UART command assembler.
// State encoding and byte width.
package uart_cmd_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    RECV = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Byte-in / command-out bundle of the assembler.
// slave = assembler side, master = environment side.
interface uart_cmd_assembler_if
  import uart_cmd_pkg::*;
#(
  parameter int NUM_BYTES = 2
);

  logic                          rx_rdy;
  logic [BYTE_W-1:0]             rx_data;
  logic                          clr_rx_rdy;
  logic [NUM_BYTES*BYTE_W-1:0]   cmd;
  logic                          cmd_rdy;
  logic                          clr_cmd_rdy;
  logic                          overrun;
  logic                          timeout;

  modport master (
    output rx_rdy,
    output rx_data,
    output clr_cmd_rdy,
    input  clr_rx_rdy,
    input  cmd,
    input  cmd_rdy,
    input  overrun,
    input  timeout
  );

  modport slave (
    input  rx_rdy,
    input  rx_data,
    input  clr_cmd_rdy,
    output clr_rx_rdy,
    output cmd,
    output cmd_rdy,
    output overrun,
    output timeout
  );

endinterface

// File: rtl/uart_cmd_assembler_idle_timer.sv
// Inter-byte idle counter for partial-frame resync.
// expired fires on the idle clock that reaches the limit.
module uart_idle_timer #(
  parameter int TIMEOUT_CLKS = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int TW =
    (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam logic [TW-1:0] LIM =
    TW'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);

  logic [TW-1:0] r_timer;
  logic          w_expired;

  // limit is hit when this idle clock would make it TIMEOUT_CLKS
  always_comb begin
    w_expired = (TIMEOUT_CLKS > 0) && en && (r_timer == LIM);
  end

  assign expired = w_expired;

  // count idle clocks; held at zero whenever not enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (clr || !en || w_expired) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs NUM_BYTES UART bytes into one command word.
// cmd_rdy/clr_cmd_rdy handshake, idle timeout, overrun.
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int NUM_BYTES    = 2,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int TIMEOUT_CLKS = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  uart_cmd_assembler_if.slave bus
);

  localparam int CMD_W = NUM_BYTES * BYTE_W;
  localparam int CNT_W =
    (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(NUM_BYTES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CMD_W-1:0] r_asm;
  logic [CMD_W-1:0] w_asm_nxt;
  logic [CMD_W-1:0] r_cmd;
  logic             r_cmd_rdy;
  logic             r_overrun;
  logic             r_timeout;
  logic             w_last;
  logic             w_accept;
  logic             w_done;
  logic             w_drop;
  logic             w_ack;
  logic             w_ovr_clr;
  logic             w_tmr_en;
  logic             w_expired;
  logic             w_clr_rx;

  assign w_last = (r_cnt == LAST);
  assign w_done = w_accept && w_last;

  // every offered byte is consumed, accepted or dropped
  assign w_clr_rx = bus.rx_rdy && rst_n;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RECV;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state and byte/ack decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_ack       = 1'b0;
    w_ovr_clr   = 1'b0;
    unique case (r_state)
      RECV: begin
        w_accept  = bus.rx_rdy;
        w_ovr_clr = bus.clr_cmd_rdy && !r_cmd_rdy;
        if (bus.rx_rdy && w_last) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_ack    = bus.clr_cmd_rdy;
        w_accept = bus.rx_rdy && bus.clr_cmd_rdy;
        w_drop   = bus.rx_rdy && !bus.clr_cmd_rdy;
        if (bus.clr_cmd_rdy && !(w_accept && w_last)) begin
          w_state_nxt = RECV;
        end
      end
      default: begin
        w_state_nxt = RECV;
      end
    endcase
  end

  // assembly word with the current byte placed
  always_comb begin
    w_asm_nxt = r_asm;
    if (MSB_FIRST) begin
      w_asm_nxt = (r_asm << BYTE_W) | CMD_W'(bus.rx_data);
    end else begin
      w_asm_nxt[int'(r_cnt)*BYTE_W +: BYTE_W] = bus.rx_data;
    end
  end

  // idle clocks only count mid-frame while receiving
  assign w_tmr_en = (TIMEOUT_CLKS > 0) &&
                    (r_state == RECV) &&
                    (r_cnt != '0) &&
                    !bus.rx_rdy;

  uart_idle_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (w_tmr_en),
    .clr    (w_accept),
    .expired(w_expired)
  );

  // frame assembly, command latch and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_asm     <= '0;
      r_cmd     <= '0;
      r_cmd_rdy <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expired;
      if (w_done) begin
        r_cmd <= w_asm_nxt;
        r_asm <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_asm <= w_asm_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_expired) begin
        r_asm <= '0;
        r_cnt <= '0;
      end
      if (w_done) begin
        r_cmd_rdy <= 1'b1;
      end else if (w_ack) begin
        r_cmd_rdy <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (w_ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.clr_rx_rdy = w_clr_rx;
  assign bus.cmd        = r_cmd;
  assign bus.cmd_rdy    = r_cmd_rdy;
  assign bus.overrun    = r_overrun;
  assign bus.timeout    = r_timeout;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench: three assembler configs fed the same byte stream.
// Directed scenarios plus random traffic vs a frame model.
module tb_uart_cmd_assembler;

  localparam int PN [3] = '{2, 4, 3};
  localparam int PM [3] = '{1, 0, 1};
  localparam int PT [3] = '{0, 0, 10};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r_rx = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic       r_clr = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  uart_cmd_assembler_if #(.NUM_BYTES(2)) ifa ();
  uart_cmd_assembler_if #(.NUM_BYTES(4)) ifb ();
  uart_cmd_assembler_if #(.NUM_BYTES(3)) ifc ();

  uart_cmd_assembler #(
    .NUM_BYTES(2), .MSB_FIRST(1'b1), .TIMEOUT_CLKS(0)
  ) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

  uart_cmd_assembler #(
    .NUM_BYTES(4), .MSB_FIRST(1'b0), .TIMEOUT_CLKS(0)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  uart_cmd_assembler #(
    .NUM_BYTES(3), .MSB_FIRST(1'b1), .TIMEOUT_CLKS(10)
  ) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  assign ifa.rx_rdy = r_rx;
  assign ifa.rx_data = r_data;
  assign ifa.clr_cmd_rdy = r_clr;
  assign ifb.rx_rdy = r_rx;
  assign ifb.rx_data = r_data;
  assign ifb.clr_cmd_rdy = r_clr;
  assign ifc.rx_rdy = r_rx;
  assign ifc.rx_data = r_data;
  assign ifc.clr_cmd_rdy = r_clr;

  logic [63:0] o_cmd [3];
  logic        o_rdy [3];
  logic        o_ovr [3];
  logic        o_to  [3];
  logic        o_clr [3];

  assign o_cmd[0] = 64'(ifa.cmd);
  assign o_cmd[1] = 64'(ifb.cmd);
  assign o_cmd[2] = 64'(ifc.cmd);
  assign o_rdy[0] = ifa.cmd_rdy;
  assign o_rdy[1] = ifb.cmd_rdy;
  assign o_rdy[2] = ifc.cmd_rdy;
  assign o_ovr[0] = ifa.overrun;
  assign o_ovr[1] = ifb.overrun;
  assign o_ovr[2] = ifc.overrun;
  assign o_to[0] = ifa.timeout;
  assign o_to[1] = ifb.timeout;
  assign o_to[2] = ifc.timeout;
  assign o_clr[0] = ifa.clr_rx_rdy;
  assign o_clr[1] = ifb.clr_rx_rdy;
  assign o_clr[2] = ifc.clr_rx_rdy;

  always #5 clk = ~clk;

  // reference: pending bytes of the open frame per config
  byte unsigned m_q [3][$];
  logic [63:0]  m_cmd [3];
  bit           m_pend [3];
  bit           m_ovr [3];
  bit           m_to [3];
  int           m_idle [3];
  int           n_clr [3];
  logic         s_clr [3];

  function automatic logic [63:0] m_word(input int id);
    logic [63:0] w = '0;
    for (int k = 0; k < m_q[id].size(); k++) begin
      if (PM[id] != 0) w = (w << 8) | 64'(m_q[id][k]);
      else w = w | (64'(m_q[id][k]) << (8 * k));
    end
    return w;
  endfunction

  function automatic void m_step(
    input int id, input bit rx,
    input byte unsigned d, input bit clr);
    bit take = 1'b0;
    m_to[id] = 1'b0;
    if (m_pend[id]) begin
      if (clr) begin
        m_pend[id] = 1'b0;
        take = rx;
      end else if (rx) begin
        m_ovr[id] = 1'b1;
      end
    end else begin
      if (clr) m_ovr[id] = 1'b0;
      take = rx;
      if (!rx && m_q[id].size() > 0 && PT[id] > 0) begin
        m_idle[id]++;
        if (m_idle[id] == PT[id]) begin
          m_q[id].delete();
          m_idle[id] = 0;
          m_to[id] = 1'b1;
        end
      end
    end
    if (take) begin
      m_q[id].push_back(d);
      m_idle[id] = 0;
    end
    if (m_q[id].size() == PN[id]) begin
      m_cmd[id] = m_word(id);
      m_pend[id] = 1'b1;
      m_q[id].delete();
      m_idle[id] = 0;
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin
      m_q[i].delete();
      m_cmd[i] = '0;
      m_pend[i] = 1'b0;
      m_ovr[i] = 1'b0;
      m_to[i] = 1'b0;
      m_idle[i] = 0;
    end
  endfunction

  task automatic cycle(
    input logic rx, input logic [7:0] d, input logic clr);
    @(negedge clk);
    r_rx = rx;
    r_data = d;
    r_clr = clr;
    #1;
    for (int i = 0; i < 3; i++) begin
      s_clr[i] = o_clr[i];
      if (o_clr[i] === 1'b1) n_clr[i]++;
      m_step(i, rx, d, clr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    r_rx = 1'b0;
    r_clr = 1'b0;
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    r_rx = 1'b0;
    r_clr = 1'b0;
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk += 5;
      if (o_cmd[i] !== 64'h0) begin
        n_err++;
        $display("FAIL rst_cmd dut%0d got %h want 0", i, o_cmd[i]);
      end
      if (o_rdy[i] !== 1'b0) begin
        n_err++;
        $display("FAIL rst_rdy dut%0d got %b want 0", i, o_rdy[i]);
      end
      if (o_ovr[i] !== 1'b0) begin
        n_err++;
        $display("FAIL rst_ovr dut%0d got %b want 0", i, o_ovr[i]);
      end
      if (o_to[i] !== 1'b0) begin
        n_err++;
        $display("FAIL rst_to dut%0d got %b want 0", i, o_to[i]);
      end
      if (o_clr[i] !== 1'b0) begin
        n_err++;
        $display("FAIL rst_clr dut%0d got %b want 0", i, o_clr[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_msb_pair();
    int c0;
    do_reset();
    c0 = n_clr[0];
    cycle(1'b1, 8'hA5, 1'b0);
    n_chk++;
    if (o_rdy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL msb_early_rdy got %b want 0", o_rdy[0]);
    end
    cycle(1'b1, 8'h3C, 1'b0);
    n_chk += 2;
    if (o_cmd[0] !== 64'hA53C) begin
      n_err++;
      $display("FAIL msb_cmd got %h want a53c", o_cmd[0]);
    end
    if (o_rdy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL msb_rdy got %b want 1", o_rdy[0]);
    end
    cycle(1'b0, 8'h00, 1'b0);
    n_chk++;
    if (n_clr[0] - c0 != 2) begin
      n_err++;
      $display("FAIL msb_clr_pulses got %0d want 2",
               n_clr[0] - c0);
    end
  endtask

  task automatic test_lsb_quad();
    do_reset();
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    n_chk++;
    if (o_rdy[1] !== 1'b0) begin
      n_err++;
      $display("FAIL lsb_early_rdy got %b want 0", o_rdy[1]);
    end
    cycle(1'b1, 8'h44, 1'b0);
    n_chk += 2;
    if (o_cmd[1] !== 64'h44332211) begin
      n_err++;
      $display("FAIL lsb_cmd got %h want 44332211", o_cmd[1]);
    end
    if (o_rdy[1] !== 1'b1) begin
      n_err++;
      $display("FAIL lsb_rdy got %b want 1", o_rdy[1]);
    end
    cycle(1'b0, 8'h00, 1'b1);
    n_chk += 2;
    if (o_rdy[1] !== 1'b0) begin
      n_err++;
      $display("FAIL lsb_ack_rdy got %b want 0", o_rdy[1]);
    end
    if (o_cmd[1] !== 64'h44332211) begin
      n_err++;
      $display("FAIL lsb_ack_cmd got %h want 44332211",
               o_cmd[1]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cycle(1'b1, 8'h01, 1'b0);
    for (int k = 0; k < 9; k++) cycle(1'b0, 8'h00, 1'b0);
    n_chk++;
    if (o_to[2] !== 1'b0) begin
      n_err++;
      $display("FAIL to_early got %b want 0", o_to[2]);
    end
    cycle(1'b0, 8'h00, 1'b0);
    n_chk += 2;
    if (o_to[2] !== 1'b1) begin
      n_err++;
      $display("FAIL to_pulse got %b want 1", o_to[2]);
    end
    if (o_rdy[2] !== 1'b0) begin
      n_err++;
      $display("FAIL to_rdy got %b want 0", o_rdy[2]);
    end
    cycle(1'b1, 8'hAA, 1'b0);
    n_chk++;
    if (o_to[2] !== 1'b0) begin
      n_err++;
      $display("FAIL to_width got %b want 0", o_to[2]);
    end
    cycle(1'b1, 8'hBB, 1'b0);
    cycle(1'b1, 8'hCC, 1'b0);
    n_chk += 2;
    if (o_cmd[2] !== 64'hAABBCC) begin
      n_err++;
      $display("FAIL to_resync_cmd got %h want aabbcc",
               o_cmd[2]);
    end
    if (o_rdy[2] !== 1'b1) begin
      n_err++;
      $display("FAIL to_resync_rdy got %b want 1", o_rdy[2]);
    end
    do_reset();
    cycle(1'b1, 8'h01, 1'b0);
    for (int k = 0; k < 9; k++) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    n_chk++;
    if (o_to[2] !== 1'b0) begin
      n_err++;
      $display("FAIL to_edge_byte got %b want 0", o_to[2]);
    end
    for (int k = 0; k < 9; k++) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    n_chk += 2;
    if (o_cmd[2] !== 64'h010203) begin
      n_err++;
      $display("FAIL to_edge_cmd got %h want 010203", o_cmd[2]);
    end
    if (o_rdy[2] !== 1'b1) begin
      n_err++;
      $display("FAIL to_edge_rdy got %b want 1", o_rdy[2]);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h34, 1'b0);
    cycle(1'b1, 8'h99, 1'b0);
    n_chk += 4;
    if (o_ovr[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_set got %b want 1", o_ovr[0]);
    end
    if (o_cmd[0] !== 64'h1234) begin
      n_err++;
      $display("FAIL ovr_cmd got %h want 1234", o_cmd[0]);
    end
    if (o_rdy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_rdy got %b want 1", o_rdy[0]);
    end
    if (s_clr[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_clr_rx got %b want 1", s_clr[0]);
    end
    cycle(1'b0, 8'h00, 1'b1);
    n_chk += 2;
    if (o_rdy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_ack_rdy got %b want 0", o_rdy[0]);
    end
    if (o_ovr[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_sticky got %b want 1", o_ovr[0]);
    end
    cycle(1'b0, 8'h00, 1'b1);
    n_chk++;
    if (o_ovr[0] !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clear got %b want 0", o_ovr[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h34, 1'b0);
    cycle(1'b1, 8'h5A, 1'b1);
    n_chk += 3;
    if (o_rdy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_rdy got %b want 0", o_rdy[0]);
    end
    if (o_ovr[0] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_ovr got %b want 0", o_ovr[0]);
    end
    if (o_cmd[0] !== 64'h1234) begin
      n_err++;
      $display("FAIL b2b_hold_cmd got %h want 1234", o_cmd[0]);
    end
    cycle(1'b1, 8'h6B, 1'b0);
    n_chk += 2;
    if (o_cmd[0] !== 64'h5A6B) begin
      n_err++;
      $display("FAIL b2b_cmd got %h want 5a6b", o_cmd[0]);
    end
    if (o_rdy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_next_rdy got %b want 1", o_rdy[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h34, 1'b0);
    cycle(1'b1, 8'h99, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h77, 1'b0);
    n_chk++;
    if (o_ovr[0] !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pre_ovr got %b want 1", o_ovr[0]);
    end
    #2;
    r_rx = 1'b0;
    rst_n = 1'b0;
    m_reset();
    #1;
    n_chk += 4;
    if (o_cmd[0] !== 64'h0) begin
      n_err++;
      $display("FAIL arst_cmd got %h want 0", o_cmd[0]);
    end
    if (o_rdy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL arst_rdy got %b want 0", o_rdy[0]);
    end
    if (o_ovr[0] !== 1'b0) begin
      n_err++;
      $display("FAIL arst_ovr got %b want 0", o_ovr[0]);
    end
    if (o_clr[0] !== 1'b0) begin
      n_err++;
      $display("FAIL arst_clr got %b want 0", o_clr[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    n_chk += 2;
    if (o_cmd[0] !== 64'h0102) begin
      n_err++;
      $display("FAIL arst_cmd_after got %h want 0102", o_cmd[0]);
    end
    if (o_rdy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL arst_rdy_after got %b want 1", o_rdy[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 900; c++) begin
      logic rx;
      logic clr;
      logic [7:0] d;
      rx = ((c % 80) < 55) ? ($urandom_range(0, 2) == 0) : 1'b0;
      clr = ($urandom_range(0, 5) == 0);
      d = 8'($urandom);
      cycle(rx, d, clr);
      for (int i = 0; i < 3; i++) begin
        n_chk += 5;
        if (s_clr[i] !== rx) begin
          n_err++;
          $display("FAIL rnd_clr_rx dut%0d cyc%0d got %b want %b",
                   i, c, s_clr[i], rx);
        end
        if (o_cmd[i] !== m_cmd[i]) begin
          n_err++;
          $display("FAIL rnd_cmd dut%0d cyc%0d got %h want %h",
                   i, c, o_cmd[i], m_cmd[i]);
        end
        if (o_rdy[i] !== m_pend[i]) begin
          n_err++;
          $display("FAIL rnd_rdy dut%0d cyc%0d got %b want %b",
                   i, c, o_rdy[i], m_pend[i]);
        end
        if (o_ovr[i] !== m_ovr[i]) begin
          n_err++;
          $display("FAIL rnd_ovr dut%0d cyc%0d got %b want %b",
                   i, c, o_ovr[i], m_ovr[i]);
        end
        if (o_to[i] !== m_to[i]) begin
          n_err++;
          $display("FAIL rnd_to dut%0d cyc%0d got %b want %b",
                   i, c, o_to[i], m_to[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      n_clr[i] = 0;
      s_clr[i] = 1'b0;
    end
    test_reset();
    test_msb_pair();
    test_lsb_quad();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
